bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter and sequencer for the shared 4-bit tri-state data bus (B0..B3) driven by the team's tri-state input registers. It owns every register's EnableIn: it grants the bus to one requesting input register, holds the enable for a settle window, strobes the destination latch, then releases the bus with a turnaround cycle. At most one driver is on the bus at any time, and the bus is never left floating during a capture.

## Interface

- NREQ, 4, number of requesting input registers; legal range 2..8
- SETTLE, 1, cycles EnableIn is held before the capture cycle; legal range 1..15
- Clock  input  1  sole clock, rising edge
- ResetN  input  1  asynchronous, active-low reset
- Req  input  NREQ  per-requester bus request, level; held until the matching Ack
- EnableIn  output  NREQ  one-hot-or-zero tri-state enable, one bit to each input register's EnableIn
- Ack  output  NREQ  one-cycle pulse to the granted requester when its data is captured
- LoadOut  output  1  one-cycle capture strobe to the destination register on the bus
- GrantId  output  clog2(NREQ)  index of the current or last granted requester
- Busy  output  1  high in every state except IDLE

## Operation

- All outputs are registered. Reset values: EnableIn=0, Ack=0, LoadOut=0, GrantId=0, Busy=0, state=IDLE, priority pointer Ptr=0, settle counter=0.
- States are IDLE, DRIVE, CAPTURE and RELEASE.
- IDLE:
  - If any Req is set, select the first set bit scanning Ptr, Ptr+1, …, wrapping mod NREQ.
  - Latch that index into GrantId, set EnableIn[GrantId]=1, load counter=SETTLE, and go to DRIVE.
  - If no Req is set, stay in IDLE.
- DRIVE:
  - EnableIn[GrantId] is held; the counter decrements each cycle.
  - When the counter reaches 1, go to CAPTURE.
  - Abort: if Req[GrantId] drops in DRIVE, clear EnableIn and go to RELEASE. No LoadOut, no Ack, and Ptr is unchanged.
- CAPTURE:
  - Exactly one cycle, with EnableIn[GrantId] still high.
  - LoadOut=1 and Ack[GrantId]=1.
  - Ptr is set to (GrantId+1) mod NREQ. Go to RELEASE.
- RELEASE:
  - Exactly one cycle with EnableIn all 0. This is bus turnaround, so no two drivers ever overlap.
  - Go to IDLE.
- Req bits other than the granted one are ignored outside IDLE.
- Req changes during CAPTURE or RELEASE have no effect on the current transfer.
- A requester that still holds Req after its Ack is a new request. It is arbitrated in IDLE using the advanced Ptr, so other pending requesters win first.
- Invariant: popcount(EnableIn) ≤ 1 in every cycle. Ack and LoadOut are asserted only together.
- GrantId keeps its last value through RELEASE and IDLE.

## Timing

- Request-to-enable: Req set in IDLE is sampled at edge N; EnableIn is high after edge N.
- Enable-to-capture: LoadOut/Ack are high SETTLE cycles after EnableIn rises.
- Transfer length: 1 (grant) + SETTLE + 1 (release), so SETTLE+2 edges from grant to IDLE. Back-to-back throughput is one transfer per SETTLE+3 cycles.
- The destination register samples the bus on the Clock edge that ends the LoadOut cycle; the bus is still driven during that cycle.
- Reset mid-operation: asynchronous assertion forces EnableIn, Ack and LoadOut to 0 immediately, without waiting for a clock edge. Ptr and GrantId return to 0.
- Deassertion of ResetN is synchronous to the first subsequent rising Clock edge.

## Test plan

- Single request, NREQ=4, SETTLE=1: Req=0100 → EnableIn=0100 for 2 cycles, then LoadOut=1 and Ack=0100 in the 2nd cycle, then one cycle of EnableIn=0000, then Busy=0; GrantId=2.
- Round-robin fairness: Req=1111 held constant → grant order 0,1,2,3,0; each Ack is one cycle; EnableIn is never multi-hot; there is a zero-enable cycle between grants.
- Settle window, SETTLE=3: Req=0001 → EnableIn=0001 for 4 cycles with LoadOut only in the 4th; total Busy = 5 cycles.
- Abort: SETTLE=3; Req=0010 then drop it in the 2nd DRIVE cycle → no LoadOut, no Ack; one RELEASE cycle; Ptr stays 1, so a following Req=0011 grants 1 first.
- Reset mid-transfer: assert ResetN=0 during CAPTURE → EnableIn, LoadOut and Ack go to 0 before the next edge; after release, Req=1000 with Ptr=0 grants 3.
- Wrap-around: Ptr=3 after granting 2, then Req=1001 → grant 3, then grant 0.

Source files
------------

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin grant/settle/capture/release sequencer for the shared
//            tri-state data bus.
// Revision : 1.0  initial release
// ============================================================================
module bus_arbiter #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 1,
    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            Clock,
    input  logic            ResetN,
    input  logic [NREQ-1:0] Req,
    output logic [NREQ-1:0] EnableIn,
    output logic [NREQ-1:0] Ack,
    output logic            LoadOut,
    output logic [PW-1:0]   GrantId,
    output logic            Busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [NREQ-1:0] c_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    state_t          r_state,    w_state;
    logic [NREQ-1:0] r_enableIn, w_enableIn;
    logic [NREQ-1:0] r_ack,      w_ack;
    logic            r_loadOut,  w_loadOut;
    logic [PW-1:0]   r_grantId,  w_grantId;
    logic            r_busy,     w_busy;
    logic [PW-1:0]   r_ptr,      w_ptr;
    logic [3:0]      r_cnt,      w_cnt;

    logic [PW-1:0]   w_pick;
    logic            w_found;
    logic [PW-1:0]   w_ptrInc;

    // First requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin : p_pick
        int            k;
        logic [PW-1:0] cand;
        w_pick  = '0;
        w_found = 1'b0;
        k       = 0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            k    = (int'(r_ptr) + i) % NREQ;
            cand = PW'(k);
            if (!w_found && Req[cand]) begin
                w_found = 1'b1;
                w_pick  = cand;
            end
        end
    end

    assign w_ptrInc = (r_grantId == PW'(NREQ - 1)) ? '0 : r_grantId + PW'(1);

    always_comb begin
        w_state    = r_state;
        w_enableIn = r_enableIn;
        w_ack      = '0;
        w_loadOut  = 1'b0;
        w_grantId  = r_grantId;
        w_ptr      = r_ptr;
        w_cnt      = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grantId  = w_pick;
                    w_enableIn = c_ONE << w_pick;
                    w_cnt      = 4'(SETTLE);
                    w_state    = DRIVE;
                end
            end
            DRIVE: begin
                // A dropped request abandons the transfer; pointer is not advanced.
                if (!Req[r_grantId]) begin
                    w_enableIn = '0;
                    w_state    = RELEASE;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state   = CAPTURE;
                        w_loadOut = 1'b1;
                        w_ack     = r_enableIn;
                    end
                end
            end
            CAPTURE: begin
                w_enableIn = '0;
                w_ptr      = w_ptrInc;
                w_state    = RELEASE;
            end
            RELEASE: begin
                w_state = IDLE;
            end
            default: begin
                w_enableIn = '0;
                w_state    = IDLE;
            end
        endcase
        w_busy = (w_state != IDLE);
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state    <= IDLE;
            r_enableIn <= '0;
            r_ack      <= '0;
            r_loadOut  <= 1'b0;
            r_grantId  <= '0;
            r_busy     <= 1'b0;
            r_ptr      <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state;
            r_enableIn <= w_enableIn;
            r_ack      <= w_ack;
            r_loadOut  <= w_loadOut;
            r_grantId  <= w_grantId;
            r_busy     <= w_busy;
            r_ptr      <= w_ptr;
            r_cnt      <= w_cnt;
        end
    end

    assign EnableIn = r_enableIn;
    assign Ack      = r_ack;
    assign LoadOut  = r_loadOut;
    assign GrantId  = r_grantId;
    assign Busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Directed bench for bus_arbiter at SETTLE=1 (A) and SETTLE=3 (B).
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;

    logic       clk;
    logic       rstA, rstB;
    logic [3:0] reqA, reqB;
    logic [3:0] enA, ackA, enB, ackB;
    logic       loadA, loadB, busyA, busyB;
    logic [1:0] gidA, gidB;
    logic [3:0] oh;

    int nCmp  = 0;
    int nFail = 0;

    bus_arbiter #(.NREQ(4), .SETTLE(1)) dutA (
        .Clock(clk), .ResetN(rstA), .Req(reqA), .EnableIn(enA), .Ack(ackA),
        .LoadOut(loadA), .GrantId(gidA), .Busy(busyA)
    );

    bus_arbiter #(.NREQ(4), .SETTLE(3)) dutB (
        .Clock(clk), .ResetN(rstB), .Req(reqB), .EnableIn(enB), .Ack(ackB),
        .LoadOut(loadB), .GrantId(gidB), .Busy(busyB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reqA = '0; reqB = '0; rstA = 1'b0; rstB = 1'b0; oh = '0;
        tick(1);
        chk("rst_en",   enA,   0);
        chk("rst_ack",  ackA,  0);
        chk("rst_load", loadA, 0);
        chk("rst_gid",  gidA,  0);
        chk("rst_busy", busyA, 0);
        chk("rstB_en",  enB,   0);
        rstA = 1'b1; rstB = 1'b1;

        // Single request, SETTLE=1
        reqA = 4'b0100;
        tick(1);
        chk("s1_en_drive", enA, 4'b0100);
        chk("s1_load_drive", loadA, 0);
        chk("s1_busy", busyA, 1);
        tick(1);
        chk("s1_en_cap", enA, 4'b0100);
        chk("s1_load_cap", loadA, 1);
        chk("s1_ack_cap", ackA, 4'b0100);
        chk("s1_gid", gidA, 2);
        reqA = '0;
        tick(1);
        chk("s1_en_rel", enA, 0);
        chk("s1_load_rel", loadA, 0);
        chk("s1_ack_rel", ackA, 0);
        chk("s1_busy_rel", busyA, 1);
        tick(1);
        chk("s1_busy_idle", busyA, 0);
        chk("s1_gid_idle", gidA, 2);

        // Round robin from a freshly reset pointer (was 3 before the reset)
        rstA = 1'b0;
        tick(1);
        rstA = 1'b1;
        reqA = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            oh = 4'b0001 << (g % 4);
            tick(1);
            chk("rr_en", enA, oh);
            chk("rr_gid", gidA, g % 4);
            tick(1);
            chk("rr_ack", ackA, oh);
            chk("rr_load", loadA, 1);
            chk("rr_onehot", $countones(enA), 1);
            tick(1);
            chk("rr_gap", enA, 0);
            chk("rr_ackgap", ackA, 0);
            tick(1);
            chk("rr_idle", busyA, 0);
        end
        reqA = '0;

        // Settle window, SETTLE=3
        reqB = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            chk("st_en",   enB,   (c < 4) ? 4'b0001 : 4'b0000);
            chk("st_load", loadB, (c == 3) ? 1 : 0);
            chk("st_ack",  ackB,  (c == 3) ? 4'b0001 : 4'b0000);
            chk("st_busy", busyB, (c < 5) ? 1 : 0);
            if (c == 3) reqB = '0;
        end

        // Abort in second DRIVE cycle; pointer is 1 here
        reqB = 4'b0010;
        tick(1);
        chk("ab_en1", enB, 4'b0010);
        tick(1);
        chk("ab_en2", enB, 4'b0010);
        reqB = '0;
        tick(1);
        chk("ab_en_rel", enB, 0);
        chk("ab_load", loadB, 0);
        chk("ab_ack", ackB, 0);
        chk("ab_busy", busyB, 1);
        tick(1);
        chk("ab_idle", busyB, 0);
        chk("ab_noack", ackB, 0);
        reqB = 4'b0011;
        tick(1);
        chk("ab_next_en", enB, 4'b0010);
        chk("ab_next_gid", gidB, 1);
        tick(3);
        chk("ab_next_ack", ackB, 4'b0010);
        reqB = 4'b0001;
        tick(1);
        chk("ab_rel_en", enB, 0);
        tick(2);
        chk("ab_then0_en", enB, 4'b0001);
        chk("ab_then0_gid", gidB, 0);
        tick(3);
        chk("ab_then0_ack", ackB, 4'b0001);
        reqB = '0;
        tick(2);

        // Wrap-around: grant 2, then 1001 grants 3 before 0
        reqB = 4'b0100;
        tick(1);
        chk("wr_gid2", gidB, 2);
        tick(3);
        chk("wr_ack2", ackB, 4'b0100);
        reqB = 4'b1001;
        tick(3);
        chk("wr_gid3", gidB, 3);
        chk("wr_en3", enB, 4'b1000);
        tick(3);
        chk("wr_ack3", ackB, 4'b1000);
        reqB = 4'b0001;
        tick(3);
        chk("wr_gid0", gidB, 0);
        chk("wr_en0", enB, 4'b0001);
        tick(3);
        chk("rs_cap_load", loadB, 1);
        chk("rs_cap_ack", ackB, 4'b0001);

        // Asynchronous reset in the middle of CAPTURE
        #2 rstB = 1'b0;
        #1;
        chk("rs_en", enB, 0);
        chk("rs_load", loadB, 0);
        chk("rs_ack", ackB, 0);
        chk("rs_busy", busyB, 0);
        reqB = 4'b1000;
        tick(1);
        rstB = 1'b1;
        tick(1);
        chk("rs_gid3", gidB, 3);
        chk("rs_en3", enB, 4'b1000);
        reqB = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
`default_nettype wire
